// File: rtl/ls_logic_seq.sv
// ---------------------------------------------------------------------------
// ls_logic_seq
// Time-shared bitwise logic unit. One LANE-bit gate slice is reused once per
// clock to build a WIDTH-bit result, so an operation takes WIDTH/LANE cycles.
// A start/ready/done handshake sits in front of a registered result and zero
// flag that feed the CPU logic-unit datapath.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous, active-low reset
//   start  in   1      request, accepted only while ready=1
//   op     in   3      000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR,
//                      101 XNOR, 110 pass A, 111 NOT A
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B (ignored for ops 110/111)
//   ready  out  1      idle, a start will be accepted
//   busy   out  1      operation in progress (always ~ready)
//   y      out  WIDTH  result register
//   zero   out  1      y == 0
//   done   out  1      one-cycle pulse, y/zero just updated
// ---------------------------------------------------------------------------
module ls_logic_seq #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             done
);

    localparam int SLICES = WIDTH / LANE;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Refuse to elaborate if the slice width does not tile the operand.
    if ((LANE < 1) || ((WIDTH % LANE) != 0)) begin : g_bad_lane
        $error("ls_logic_seq: LANE must divide WIDTH exactly");
    end

    // One gate slice: the shared LANE-bit logic function.
    function automatic logic [LANE-1:0] slice_op(
        input logic [2:0]      f_op,
        input logic [LANE-1:0] f_a,
        input logic [LANE-1:0] f_b
    );
        logic [LANE-1:0] f_r;
        case (f_op)
            3'b000:  f_r = f_a & f_b;
            3'b001:  f_r = f_a | f_b;
            3'b010:  f_r = f_a ^ f_b;
            3'b011:  f_r = ~(f_a & f_b);
            3'b100:  f_r = ~(f_a | f_b);
            3'b101:  f_r = ~(f_a ^ f_b);
            3'b110:  f_r = f_a;
            3'b111:  f_r = ~f_a;
            default: f_r = {LANE{1'b0}};
        endcase
        return f_r;
    endfunction

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_done;

    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_last = (r_idx == IDX_LAST);

    // Accumulator with the current slice merged in; only the slice selected
    // by r_idx is replaced, the rest keep what earlier cycles wrote.
    always_comb begin
        w_acc_next = r_acc;
        for (int s = 0; s < SLICES; s++) begin
            if (r_idx == IDX_W'(s)) begin
                w_acc_next[s*LANE +: LANE] = slice_op(r_op,
                                                      r_a[s*LANE +: LANE],
                                                      r_b[s*LANE +: LANE]);
            end else begin
                w_acc_next[s*LANE +: LANE] = r_acc[s*LANE +: LANE];
            end
        end
    end

    // Handshake FSM, operand latches, slice sequencing and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_op    <= 3'b000;
            r_idx   <= {IDX_W{1'b0}};
            r_acc   <= {WIDTH{1'b0}};
            r_y     <= {WIDTH{1'b0}};
            r_zero  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the last slice re-asserts it
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_idx   <= {IDX_W{1'b0}};
                        r_acc   <= {WIDTH{1'b0}};
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        // y/zero only ever see a complete result
                        r_y     <= w_acc_next;
                        r_zero  <= (w_acc_next == {WIDTH{1'b0}});
                        r_done  <= 1'b1;
                        r_idx   <= {IDX_W{1'b0}};
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + IDX_ONE;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state == S_RUN);
    assign y     = r_y;
    assign zero  = r_zero;
    assign done  = r_done;

endmodule

// File: tb/tb_ls_logic_seq.sv
module tb_ls_logic_seq;

    typedef struct {
        logic [31:0] y;
        logic        z;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        start0, start1, start2;

    logic        ready0, busy0, zero0, done0;
    logic [15:0] y0;
    logic        ready1, busy1, zero1, done1;
    logic [7:0]  y1;
    logic        ready2, busy2, zero2, done2;
    logic [31:0] y2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    ls_logic_seq #(.WIDTH(16), .LANE(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op(op_s),
        .a(a_s[15:0]), .b(b_s[15:0]), .ready(ready0), .busy(busy0),
        .y(y0), .zero(zero0), .done(done0));

    ls_logic_seq #(.WIDTH(8), .LANE(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op_s),
        .a(a_s[7:0]), .b(b_s[7:0]), .ready(ready1), .busy(busy1),
        .y(y1), .zero(zero1), .done(done1));

    ls_logic_seq #(.WIDTH(32), .LANE(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op_s),
        .a(a_s), .b(b_s), .ready(ready2), .busy(busy2),
        .y(y2), .zero(zero2), .done(done2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Plain bitwise reference on full 32-bit words.
    function automatic logic [31:0] ref_op(input logic [2:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] w);
        case (o)
            3'd0:    return x & w;
            3'd1:    return x | w;
            3'd2:    return x ^ w;
            3'd3:    return ~(x & w);
            3'd4:    return ~(x | w);
            3'd5:    return ~(x ^ w);
            3'd6:    return x;
            default: return ~x;
        endcase
    endfunction

    function automatic logic cur_ready(input int which);
        if (which == 0) return ready0;
        else if (which == 1) return ready1;
        else return ready2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    // Caller is at a negedge. Waits for ready, drives a one-cycle start and
    // optionally pushes the expected result and completion cycle.
    task automatic issue(input int which, input logic [2:0] o,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] ey, input bit push);
        int n = 0;
        int sl;
        exp_t e;
        sl = (which == 0) ? 4 : ((which == 1) ? 1 : 8);
        while (!cur_ready(which) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready(which)) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut%0d got 0 expected 1", which);
        end
        op_s = o;
        a_s  = aa;
        b_s  = bb;
        if (which == 0) start0 = 1'b1;
        else if (which == 1) start1 = 1'b1;
        else start2 = 1'b1;
        if (push) begin
            e.y   = ey;
            e.z   = (ey == 32'd0);
            e.cyc = cyc + 1 + sl;
            if (which == 0) q0.push_back(e);
            else if (which == 1) q1.push_back(e);
            else q2.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!done0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got 0 expected 1");
        end
    endtask

    // Scoreboard monitors: every done pops one expectation.
    always @(negedge clk) begin
        if (done0) begin
            exp_t e;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL d0_unexpected_done y=%h expected no done", y0);
            end else begin
                e = q0.pop_front();
                if (y0 !== e.y[15:0] || zero0 !== e.z || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL d0_result got y=%h z=%b cyc=%0d expected y=%h z=%b cyc=%0d",
                             y0, zero0, cyc, e.y[15:0], e.z, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            exp_t e;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL d1_unexpected_done y=%h expected no done", y1);
            end else begin
                e = q1.pop_front();
                if (y1 !== e.y[7:0] || zero1 !== e.z || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL d1_result got y=%h z=%b cyc=%0d expected y=%h z=%b cyc=%0d",
                             y1, zero1, cyc, e.y[7:0], e.z, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            exp_t e;
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL d2_unexpected_done y=%h expected no done", y2);
            end else begin
                e = q2.pop_front();
                if (y2 !== e.y || zero2 !== e.z || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL d2_result got y=%h z=%b cyc=%0d expected y=%h z=%b cyc=%0d",
                             y2, zero2, cyc, e.y, e.z, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        op_s   = 3'd0;
        a_s    = 32'd0;
        b_s    = 32'd0;

        // Reset held for two edges; start during reset must be dropped.
        @(posedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        chk("rst_ready", {31'd0, ready0}, 32'd1);
        chk("rst_busy",  {31'd0, busy0},  32'd0);
        chk("rst_y",     {16'd0, y0},     32'h0000);
        chk("rst_zero",  {31'd0, zero0},  32'd1);
        chk("rst_done",  {31'd0, done0},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {31'd0, busy0}, 32'd0);

        // AND; y must hold its old value through the whole run.
        issue(0, 3'b000, 32'h0000A5F0, 32'h0000CC0F, 32'h00008400, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("and_busy",    {31'd0, busy0},  32'd1);
            chk("and_ready",   {31'd0, ready0}, 32'd0);
            chk("and_y_hold",  {16'd0, y0},     32'h0000);
            @(negedge clk);
        end
        chk("and_done_pulse", {31'd0, done0}, 32'd1);
        @(negedge clk);
        chk("and_done_clear", {31'd0, done0}, 32'd0);

        // Back-to-back XOR then NAND started in the XOR done cycle.
        issue(0, 3'b010, 32'h0000A5F0, 32'h0000CC0F, 32'h000069FF, 1'b1);
        wait_done0();
        chk("xor_ready_in_done", {31'd0, ready0}, 32'd1);
        issue(0, 3'b011, 32'h0000FFFF, 32'h00000000, 32'h0000FFFF, 1'b1);
        chk("nand_busy_no_bubble", {31'd0, busy0}, 32'd1);
        chk("nand_done_cleared",   {31'd0, done0}, 32'd0);
        wait_done0();
        @(negedge clk);

        // Reset in mid-operation: no done, reset values restored.
        issue(0, 3'b001, 32'h00001234, 32'h00004321, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_y",     {16'd0, y0},     32'h0000);
        chk("abort_zero",  {31'd0, zero0},  32'd1);
        chk("abort_ready", {31'd0, ready0}, 32'd1);
        chk("abort_done",  {31'd0, done0},  32'd0);
        repeat (6) @(negedge clk);

        // Zero result; mid-run input changes and start are ignored.
        issue(0, 3'b000, 32'h00000F0F, 32'h0000F0F0, 32'h00000000, 1'b1);
        op_s   = 3'b001;
        a_s    = 32'hFFFFFFFF;
        b_s    = 32'hFFFFFFFF;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0();
        chk("zero_flag", {31'd0, zero0}, 32'd1);
        repeat (8) @(negedge clk);

        // Parameter sweep: all ops on random operands, 8/8 and 32/4.
        for (int o = 0; o < 8; o++) begin
            ra = $urandom;
            rb = $urandom;
            issue(1, 3'(o), ra, rb, ref_op(3'(o), ra, rb) & 32'h000000FF, 1'b1);
            issue(2, 3'(o), ra, rb, ref_op(3'(o), ra, rb), 1'b1);
        end
        // Zero-result corners for both swept widths.
        issue(1, 3'b101, 32'h0000005A, 32'h000000A5, 32'h00000000, 1'b1);
        issue(2, 3'b000, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1);
        repeat (20) @(negedge clk);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
